// File: rtl/pdm_pkg.sv
// Shared widths, types and helpers for the PDM transmit path.
package pdm_pkg;

  localparam int unsigned PDM_ACC_GUARD = 4;
  localparam int unsigned PDM_SAMPLE_W  = 16;
  localparam int unsigned PDM_SAT_W     = 64;

  typedef logic signed [PDM_SAMPLE_W-1:0] pcm_t;

  // Bit-clock divider: integer floor of the frequency ratio.
  function automatic int unsigned pdm_div(input longint unsigned in_freq,
                                          input longint unsigned pdm_freq);
    return 32'(in_freq / pdm_freq);
  endfunction

  // Symmetric saturation to +/-(2^(acc_w-1)-1), computed on a wide signed value.
  function automatic logic signed [PDM_SAT_W-1:0] sat_acc(input logic signed [PDM_SAT_W-1:0] v,
                                                          input int unsigned acc_w);
    logic signed [PDM_SAT_W-1:0] lim;
    lim = (64'sd1 <<< (acc_w - 32'd1)) - 64'sd1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/pdm_sd_mod2.sv
// Second-order sigma-delta modulator: two saturating integrators, 1-bit quantiser.
module pdm_sd_mod2
  import pdm_pkg::*;
#(
  parameter int unsigned SAMPLE_W = PDM_SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       step,
  input  logic signed [SAMPLE_W-1:0] x,
  output logic                       bit_out
);

  localparam int unsigned ACC_W = SAMPLE_W + PDM_ACC_GUARD;
  localparam logic signed [PDM_SAT_W-1:0] FS = 64'sd1 <<< (SAMPLE_W - 1);

  logic signed [ACC_W-1:0]     i1_q, i1_d;
  logic signed [ACC_W-1:0]     i2_q, i2_d;
  logic                        bit_q, bit_d;
  logic signed [PDM_SAT_W-1:0] fb;

  // Loop update; the feedback is the bit currently on the line.
  always_comb begin
    i1_d  = i1_q;
    i2_d  = i2_q;
    bit_d = bit_q;
    fb    = bit_q ? FS : -FS;
    if (step) begin
      i1_d  = ACC_W'(sat_acc(PDM_SAT_W'(i1_q) + PDM_SAT_W'(x) - fb, ACC_W));
      i2_d  = ACC_W'(sat_acc(PDM_SAT_W'(i2_q) + PDM_SAT_W'(i1_d) - fb, ACC_W));
      bit_d = ~i2_d[ACC_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q  <= '0;
      i2_q  <= '0;
      bit_q <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      bit_q <= bit_d;
    end
  end

  assign bit_out = bit_q;

endmodule

// File: rtl/pdm_audio_out.sv
// PDM transmitter: PCM valid/ready intake, 1-deep sample buffer, bit-clock divider
// and a second-order sigma-delta modulator driving PDM_DATA.
module pdm_audio_out
  import pdm_pkg::*;
#(
  parameter longint unsigned INPUT_FREQ = 100000000,
  parameter longint unsigned PDM_FREQ   = 2400000,
  parameter int unsigned     SAMPLE_W   = PDM_SAMPLE_W,
  parameter int unsigned     OSR        = 50
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] s_pcm_tdata,
  input  logic                       s_pcm_tvalid,
  output logic                       s_pcm_tready,
  output logic                       underflow,
  output logic                       PDM_CLK,
  output logic                       PDM_DATA
);

  localparam int unsigned DIV   = pdm_div(INPUT_FREQ, PDM_FREQ);
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned BIT_W = $clog2(OSR);

  logic [CNT_W-1:0]           clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic                       pdm_clk_q, pdm_clk_d;
  logic signed [SAMPLE_W-1:0] cur_q, cur_d;
  logic signed [SAMPLE_W-1:0] nxt_q, nxt_d;
  logic                       nxt_full_q, nxt_full_d;
  logic                       tready_q, tready_d;
  logic                       uf_q, uf_d;
  logic                       fall_tick_c;
  logic                       boundary_c;
  logic                       hs_c;

  // Divider, bit counter and sample buffer next-state.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    nxt_full_d = nxt_full_q;
    uf_d       = 1'b0;

    clk_cnt_d   = (clk_cnt_q == CNT_W'(DIV - 1)) ? '0 : clk_cnt_q + CNT_W'(1);
    pdm_clk_d   = (clk_cnt_d < CNT_W'(HALF));
    fall_tick_c = (clk_cnt_q == CNT_W'(HALF - 1));
    boundary_c  = fall_tick_c && (bit_cnt_q == BIT_W'(OSR - 1));
    hs_c        = s_pcm_tvalid && tready_q;

    if (fall_tick_c) begin
      bit_cnt_d = boundary_c ? '0 : bit_cnt_q + BIT_W'(1);
    end

    // At a boundary the buffered sample wins; an empty buffer takes a same-cycle
    // handshake straight through, otherwise the stream mutes and flags underflow.
    if (boundary_c) begin
      if (nxt_full_q) begin
        cur_d      = nxt_q;
        nxt_full_d = 1'b0;
      end else if (hs_c) begin
        cur_d = s_pcm_tdata;
      end else begin
        cur_d = '0;
        uf_d  = 1'b1;
      end
    end else if (hs_c) begin
      nxt_d      = s_pcm_tdata;
      nxt_full_d = 1'b1;
    end

    tready_d = !nxt_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      pdm_clk_q  <= 1'b0;
      cur_q      <= '0;
      nxt_q      <= '0;
      nxt_full_q <= 1'b0;
      tready_q   <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      pdm_clk_q  <= pdm_clk_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      nxt_full_q <= nxt_full_d;
      tready_q   <= tready_d;
      uf_q       <= uf_d;
    end
  end

  // The modulator steps on the edge that drops PDM_CLK, so PDM_DATA is stable while high.
  pdm_sd_mod2 #(
    .SAMPLE_W(SAMPLE_W)
  ) u_mod (
    .clk    (clk),
    .rst    (rst),
    .step   (fall_tick_c),
    .x      (cur_q),
    .bit_out(PDM_DATA)
  );

  assign PDM_CLK      = pdm_clk_q;
  assign s_pcm_tready = tready_q;
  assign underflow    = uf_q;

endmodule

// File: tb/tb_pdm_audio_out.sv
// Directed bench for pdm_audio_out: reset, densities, backpressure, underflow/bypass, timing.
module tb_pdm_audio_out;
  import pdm_pkg::*;

  localparam int DIV = 41;
  localparam int OSR = 50;

  logic clk = 1'b0;
  logic rst;
  pcm_t tdata;
  logic tvalid;
  logic tready, uf, pclk, pdata;

  pdm_audio_out dut (
    .clk         (clk),
    .rst         (rst),
    .s_pcm_tdata (tdata),
    .s_pcm_tvalid(tvalid),
    .s_pcm_tready(tready),
    .underflow   (uf),
    .PDM_CLK     (pclk),
    .PDM_DATA    (pdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int   falls, ones, accepts, uf_cnt;
  logic count_ones, fell;
  logic mon_en, have_rise, prev_clk, prev_data;
  int   since_rise, last_high, last_period, bad_high, bad_period, bad_data;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: count the handshake the coming edge will see, then sample outputs.
  task automatic step();
    logic rise;
    if (tvalid && tready && !rst) accepts++;
    @(posedge clk);
    #1;
    rise = !prev_clk && pclk;
    fell = prev_clk && !pclk;
    if (uf) uf_cnt++;
    if (fell) falls++;
    if (rise && count_ones && pdata) ones++;
    if (mon_en) begin
      since_rise++;
      if (prev_clk && pclk && (pdata != prev_data)) bad_data++;
      if (fell && have_rise) begin
        last_high = since_rise;
        if (since_rise != DIV / 2) bad_high++;
      end
      if (rise) begin
        if (have_rise) begin
          last_period = since_rise;
          if (since_rise != DIV) bad_period++;
        end
        have_rise  = 1'b1;
        since_rise = 0;
      end
    end
    prev_clk  = pclk;
    prev_data = pdata;
  endtask

  task automatic run_falls(input int n);
    int target;
    int budget;
    target = falls + n;
    budget = (n + 2) * DIV;
    while (falls < target && budget > 0) begin
      step();
      budget--;
    end
    if (falls < target) check_eq("run_falls_timeout", 64'(falls), 64'(target));
  endtask

  task automatic wait_accept();
    int start;
    int budget;
    start  = accepts;
    budget = (OSR + 2) * DIV;
    while (accepts == start && budget > 0) begin
      step();
      budget--;
    end
    if (accepts == start) check_eq("wait_accept_timeout", 64'(accepts), 64'(start + 1));
  endtask

  task automatic reset_dut(input string tag, input int ncyc);
    rst       = 1'b1;
    mon_en    = 1'b0;
    have_rise = 1'b0;
    repeat (ncyc) step();
    check_eq({tag, "_pdm_clk"}, 64'(pclk), 64'd0);
    check_eq({tag, "_pdm_data"}, 64'(pdata), 64'd0);
    check_eq({tag, "_underflow"}, 64'(uf), 64'd0);
    check_eq({tag, "_tready_in_rst"}, 64'(tready), 64'd0);
    falls   = 0;
    accepts = 0;
    uf_cnt  = 0;
    ones    = 0;
    rst     = 1'b0;
    step();
    mon_en = 1'b1;
    check_eq({tag, "_tready_after"}, 64'(tready), 64'd1);
  endtask

  task automatic density(input string tag, input int x, input int lo, input int hi);
    reset_dut({tag, "_rst"}, 3);
    tdata  = 16'(x);
    tvalid = 1'b1;
    run_falls(55);
    ones       = 0;
    count_ones = 1'b1;
    run_falls(300);
    count_ones = 1'b0;
    $display("[TB] %s: %0d ones in 300 bits", tag, ones);
    check_eq({tag, "_in_range"}, 64'(ones >= lo && ones <= hi), 64'd1);
    check_eq({tag, "_underflow"}, 64'(uf_cnt), 64'd0);
  endtask

  initial begin
    int acc0;
    rst = 1'b1; tvalid = 1'b0; tdata = '0;
    count_ones = 1'b0; mon_en = 1'b0; have_rise = 1'b0; fell = 1'b0;
    prev_clk = 1'b0; prev_data = 1'b0;
    falls = 0; ones = 0; accepts = 0; uf_cnt = 0;
    since_rise = 0; last_high = 0; last_period = 0;
    bad_high = 0; bad_period = 0; bad_data = 0;

    reset_dut("por", 5);

    // Zero input with tvalid held: half density, one accept per sample period.
    tdata  = '0;
    tvalid = 1'b1;
    run_falls(50);
    ones       = 0;
    count_ones = 1'b1;
    run_falls(300);
    count_ones = 1'b0;
    $display("[TB] zero: %0d ones in 300 bits", ones);
    check_eq("zero_density", 64'(ones >= 148 && ones <= 152), 64'd1);
    step();
    check_eq("bp_tready_low", 64'(tready), 64'd0);
    check_eq("bp_accepts", 64'(accepts), 64'(1 + falls / OSR));
    check_eq("zero_underflow", 64'(uf_cnt), 64'd0);

    density("dens_m16k", -16384, 72, 78);
    density("dens_max", 32767, 297, 300);
    density("dens_p16k", 16384, 222, 228);

    // Stop feeding right after a handshake: buffered sample plays, then mute.
    wait_accept();
    tvalid = 1'b0;
    uf_cnt = 0;
    run_falls(120);
    check_eq("uf_first_pulse", 64'(uf_cnt), 64'd1);
    ones       = 0;
    count_ones = 1'b1;
    run_falls(100);
    count_ones = 1'b0;
    $display("[TB] mute: %0d ones in 100 bits", ones);
    check_eq("uf_pulse_count", 64'(uf_cnt), 64'd3);
    check_eq("mute_density", 64'(ones >= 46 && ones <= 54), 64'd1);

    // Present a sample only on the boundary cycle with the buffer empty.
    run_falls(29);
    repeat (DIV - 1) step();
    tdata  = 16'sd12345;
    tvalid = 1'b1;
    uf_cnt = 0;
    acc0   = accepts;
    step();
    tvalid = 1'b0;
    check_eq("byp_on_boundary", 64'(fell), 64'd1);
    check_eq("byp_no_uf", 64'(uf), 64'd0);
    check_eq("byp_accepted", 64'(accepts - acc0), 64'd1);
    check_eq("byp_tready", 64'(tready), 64'd1);
    run_falls(50);
    check_eq("byp_consumed", 64'(uf_cnt), 64'd1);

    // Reset in the middle of a sample period, then restart cleanly.
    reset_dut("pre_mid", 5);
    tdata  = '0;
    tvalid = 1'b1;
    run_falls(25);
    repeat (25) step();
    check_eq("mid_pclk_high", 64'(pclk), 64'd1);
    reset_dut("mid_rst", 1);
    run_falls(60);
    check_eq("mid_no_uf", 64'(uf_cnt), 64'd0);
    check_eq("mid_accepts", 64'(accepts), 64'd2);

    check_eq("pdm_period", 64'(last_period), 64'd41);
    check_eq("pdm_high", 64'(last_high), 64'd20);
    check_eq("pdm_bad_period", 64'(bad_period), 64'd0);
    check_eq("pdm_bad_high", 64'(bad_high), 64'd0);
    check_eq("pdm_data_while_high", 64'(bad_data), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
